// File: rtl/atm_controller.sv
// ATM transaction controller: checks a 4-digit BCD PIN against the card, locks after
// repeated failures, and applies deposits/withdrawals to an internal 64-bit balance.
module atm_controller #(
    parameter logic [63:0] BALANCE_INICIAL = 64'd0,
    parameter logic [1:0]  MAX_INTENTOS    = 2'd3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        TARJETA_RECIBIDA,
    input  logic [15:0] PIN,
    input  logic [3:0]  DIGITO,
    input  logic        DIGITO_STB,
    input  logic        TIPO_TRANS,
    input  logic [31:0] MONTO,
    input  logic        MONTO_STB,
    output logic        BALANCE_ACTUALIZADO,
    output logic        ENTREGAR_DINERO,
    output logic        FONDOS_INSUFICIENTES,
    output logic        PIN_INCORRECTO,
    output logic        ADVERTENCIA,
    output logic        Bloqueo
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PIN_ENT   = 3'd1,
        COMPARA   = 3'd2,
        ESP_MONTO = 3'd3,
        FIN       = 3'd4,
        BLOQUEO   = 3'd5
    } state_t;

    // Digit idx selects the stored nibble; first keyed digit is the least significant.
    function automatic logic [3:0] pin_digit(input logic [15:0] pin, input logic [1:0] idx);
        logic [3:0] d;
        case (idx)
            2'd0:    d = pin[3:0];
            2'd1:    d = pin[7:4];
            2'd2:    d = pin[11:8];
            2'd3:    d = pin[15:12];
            default: d = 4'd0;
        endcase
        return d;
    endfunction

    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[64] ? {64{1'b1}} : s[63:0];
    endfunction

    state_t      state_q;
    logic        dig_stb_q;
    logic        mon_stb_q;
    logic [1:0]  dig_cnt_q;
    logic        mismatch_q;
    logic [1:0]  intentos_q;
    logic [63:0] balance_q;
    logic        bal_act_q;
    logic        entregar_q;
    logic        fondos_q;
    logic        pin_inc_q;
    logic        adv_q;
    logic        bloqueo_q;

    logic        dig_edge_s;
    logic        mon_edge_s;
    logic        dig_bad_s;
    logic [1:0]  intentos_inc_s;
    logic [63:0] monto_ext_s;

    assign dig_edge_s     = DIGITO_STB & ~dig_stb_q;
    assign mon_edge_s     = MONTO_STB & ~mon_stb_q;
    assign dig_bad_s      = (DIGITO != pin_digit(PIN, dig_cnt_q));
    assign intentos_inc_s = intentos_q + 2'd1;
    assign monto_ext_s    = {32'd0, MONTO};

    // Previous-cycle copies of the strobes for rising-edge detection.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            dig_stb_q <= 1'b0;
            mon_stb_q <= 1'b0;
        end else begin
            dig_stb_q <= DIGITO_STB;
            mon_stb_q <= MONTO_STB;
        end
    end

    // Transaction state machine with registered status outputs and balance.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            dig_cnt_q  <= 2'd0;
            mismatch_q <= 1'b0;
            intentos_q <= 2'd0;
            balance_q  <= BALANCE_INICIAL;
            bal_act_q  <= 1'b0;
            entregar_q <= 1'b0;
            fondos_q   <= 1'b0;
            pin_inc_q  <= 1'b0;
            adv_q      <= 1'b0;
            bloqueo_q  <= 1'b0;
        end else begin
            pin_inc_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (TARJETA_RECIBIDA) begin
                        state_q    <= PIN_ENT;
                        dig_cnt_q  <= 2'd0;
                        mismatch_q <= 1'b0;
                    end
                end
                PIN_ENT: begin
                    if (!TARJETA_RECIBIDA) begin
                        state_q    <= IDLE;
                        intentos_q <= 2'd0;
                        adv_q      <= 1'b0;
                    end else if (dig_edge_s) begin
                        mismatch_q <= mismatch_q | dig_bad_s;
                        dig_cnt_q  <= dig_cnt_q + 2'd1;
                        if (dig_cnt_q == 2'd3) begin
                            state_q <= COMPARA;
                        end
                    end
                end
                COMPARA: begin
                    if (!TARJETA_RECIBIDA) begin
                        state_q    <= IDLE;
                        intentos_q <= 2'd0;
                        adv_q      <= 1'b0;
                    end else if (!mismatch_q) begin
                        state_q    <= ESP_MONTO;
                        intentos_q <= 2'd0;
                        adv_q      <= 1'b0;
                    end else begin
                        intentos_q <= intentos_inc_s;
                        pin_inc_q  <= 1'b1;
                        if (intentos_inc_s == MAX_INTENTOS) begin
                            state_q   <= BLOQUEO;
                            bloqueo_q <= 1'b1;
                            adv_q     <= 1'b0;
                        end else begin
                            if (intentos_inc_s == (MAX_INTENTOS - 2'd1)) begin
                                adv_q <= 1'b1;
                            end
                            state_q    <= PIN_ENT;
                            dig_cnt_q  <= 2'd0;
                            mismatch_q <= 1'b0;
                        end
                    end
                end
                ESP_MONTO: begin
                    if (!TARJETA_RECIBIDA) begin
                        state_q    <= IDLE;
                        intentos_q <= 2'd0;
                        adv_q      <= 1'b0;
                    end else if (mon_edge_s) begin
                        state_q <= FIN;
                        if (!TIPO_TRANS) begin
                            balance_q <= sat_add(balance_q, monto_ext_s);
                            bal_act_q <= 1'b1;
                        end else if (monto_ext_s <= balance_q) begin
                            balance_q  <= balance_q - monto_ext_s;
                            bal_act_q  <= 1'b1;
                            entregar_q <= 1'b1;
                        end else begin
                            fondos_q <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    if (!TARJETA_RECIBIDA) begin
                        state_q    <= IDLE;
                        bal_act_q  <= 1'b0;
                        entregar_q <= 1'b0;
                        fondos_q   <= 1'b0;
                    end
                end
                BLOQUEO: begin
                    bloqueo_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign BALANCE_ACTUALIZADO  = bal_act_q;
    assign ENTREGAR_DINERO      = entregar_q;
    assign FONDOS_INSUFICIENTES = fondos_q;
    assign PIN_INCORRECTO       = pin_inc_q;
    assign ADVERTENCIA          = adv_q;
    assign Bloqueo              = bloqueo_q;

endmodule

// File: tb/tb_atm_controller.sv
// Directed plus randomized bench for atm_controller against a session-level reference model.
module tb_atm_controller;

    logic        Clk;
    logic        Reset;
    logic        TARJETA_RECIBIDA;
    logic [15:0] PIN;
    logic [3:0]  DIGITO;
    logic        DIGITO_STB;
    logic        TIPO_TRANS;
    logic [31:0] MONTO;
    logic        MONTO_STB;
    logic        BALANCE_ACTUALIZADO;
    logic        ENTREGAR_DINERO;
    logic        FONDOS_INSUFICIENTES;
    logic        PIN_INCORRECTO;
    logic        ADVERTENCIA;
    logic        Bloqueo;

    atm_controller dut (
        .Clk                 (Clk),
        .Reset               (Reset),
        .TARJETA_RECIBIDA    (TARJETA_RECIBIDA),
        .PIN                 (PIN),
        .DIGITO              (DIGITO),
        .DIGITO_STB          (DIGITO_STB),
        .TIPO_TRANS          (TIPO_TRANS),
        .MONTO               (MONTO),
        .MONTO_STB           (MONTO_STB),
        .BALANCE_ACTUALIZADO (BALANCE_ACTUALIZADO),
        .ENTREGAR_DINERO     (ENTREGAR_DINERO),
        .FONDOS_INSUFICIENTES(FONDOS_INSUFICIENTES),
        .PIN_INCORRECTO      (PIN_INCORRECTO),
        .ADVERTENCIA         (ADVERTENCIA),
        .Bloqueo             (Bloqueo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int vectors    = 0;
    int miscompares = 0;
    int pulse_cnt  = 0;

    // Reference model state
    logic [63:0] m_bal;
    int          m_att;
    bit          m_warn, m_lock, m_act, m_ent, m_fon;
    int          m_pulses;
    logic [15:0] cur_pin;

    always @(negedge Clk) begin
        if (PIN_INCORRECTO === 1'b1) pulse_cnt++;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".bal_act"},  64'(BALANCE_ACTUALIZADO),  64'(m_act));
        chk({tag, ".entregar"}, 64'(ENTREGAR_DINERO),      64'(m_ent));
        chk({tag, ".fondos"},   64'(FONDOS_INSUFICIENTES), 64'(m_fon));
        chk({tag, ".adv"},      64'(ADVERTENCIA),          64'(m_warn));
        chk({tag, ".bloqueo"},  64'(Bloqueo),              64'(m_lock));
        chk({tag, ".pulses"},   64'(pulse_cnt),            64'(m_pulses));
        chk({tag, ".balance"},  dut.balance_q,             m_bal);
    endtask

    task automatic model_reset();
        m_bal = 64'd0; m_att = 0; m_warn = 1'b0; m_lock = 1'b0;
        m_act = 1'b0; m_ent = 1'b0; m_fon = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b0;
        #2;
        model_reset();
        check_all(tag);
        TARJETA_RECIBIDA = 1'b0; DIGITO_STB = 1'b0; MONTO_STB = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
    endtask

    task automatic card_in(input logic [15:0] pin);
        cur_pin = pin;
        PIN = pin;
        TARJETA_RECIBIDA = 1'b1;
        tick();
    endtask

    task automatic card_out();
        TARJETA_RECIBIDA = 1'b0;
        tick(); tick();
        if (!m_lock) begin
            m_act = 1'b0; m_ent = 1'b0; m_fon = 1'b0; m_att = 0; m_warn = 1'b0;
        end
    endtask

    task automatic key(input logic [3:0] d);
        DIGITO = d;
        DIGITO_STB = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        DIGITO_STB = 1'b0;
        tick();
    endtask

    // ent[3:0] is keyed first
    task automatic attempt(input logic [15:0] ent);
        for (int i = 0; i < 4; i++) key(ent[4*i +: 4]);
        tick(); tick();
        if (ent == cur_pin) begin
            m_att = 0; m_warn = 1'b0;
        end else begin
            m_att++; m_pulses++;
            if (m_att >= 3) begin
                m_lock = 1'b1; m_warn = 1'b0;
            end else begin
                m_warn = (m_att == 2);
            end
        end
    endtask

    task automatic amount(input bit tipo, input logic [31:0] monto);
        logic [63:0] s;
        TIPO_TRANS = tipo;
        MONTO = monto;
        MONTO_STB = 1'b1;
        tick();
        MONTO_STB = 1'b0;
        tick();
        if (!tipo) begin
            s = m_bal + 64'(monto);
            if (s < m_bal) s = {64{1'b1}};
            m_bal = s; m_act = 1'b1;
        end else if (64'(monto) <= m_bal) begin
            m_bal = m_bal - 64'(monto); m_act = 1'b1; m_ent = 1'b1;
        end else begin
            m_fon = 1'b1;
        end
    endtask

    function automatic logic [15:0] rand_pin();
        logic [15:0] p;
        for (int i = 0; i < 4; i++) p[4*i +: 4] = 4'($urandom_range(0, 9));
        return p;
    endfunction

    function automatic logic [15:0] wrong_pin(input logic [15:0] p);
        logic [15:0] w;
        int          k;
        w = p;
        k = $urandom_range(0, 3);
        w[4*k +: 4] = 4'((int'(p[4*k +: 4]) + $urandom_range(1, 9)) % 10);
        return w;
    endfunction

    initial begin
        logic [15:0] ent;
        bit          done;
        bit          tipo;
        logic [31:0] monto;

        Reset = 1'b0; TARJETA_RECIBIDA = 1'b0; PIN = 16'd0; DIGITO = 4'd0;
        DIGITO_STB = 1'b0; TIPO_TRANS = 1'b0; MONTO = 32'd0; MONTO_STB = 1'b0;
        m_pulses = 0;
        do_reset("reset");

        // Deposit 10000, withdraw 9000, withdraw 2000 rejected
        card_in(16'h5916); attempt(16'h5916); check_all("dep_pin");
        amount(1'b0, 32'd10000); check_all("dep10000");
        card_out(); check_all("dep_out");
        card_in(16'h5916); attempt(16'h5916); amount(1'b1, 32'd9000); check_all("wd9000");
        card_out(); check_all("wd9000_out");
        card_in(16'h5916); attempt(16'h5916); amount(1'b1, 32'd2000); check_all("wd2000");
        card_out(); check_all("wd2000_out");
        // Zero withdraw and exact-balance withdraw both succeed
        card_in(16'h5916); attempt(16'h5916); amount(1'b1, 32'd0); check_all("wd0");
        card_out();
        card_in(16'h5916); attempt(16'h5916); amount(1'b1, 32'd1000); check_all("wd_exact");
        card_out(); check_all("wd_exact_out");

        // Three wrong attempts lock; card removal and strobes ignored
        card_in(16'h5916);
        attempt(16'h4916); check_all("bad1");
        attempt(16'h5917); check_all("bad2");
        attempt(16'h5316); check_all("bad3");
        card_out(); check_all("lock_card_out");
        MONTO_STB = 1'b1; tick(); MONTO_STB = 1'b0; tick();
        check_all("lock_strobe");
        do_reset("lock_reset");

        // Reset while a deposit strobe is pending
        card_in(16'h5916); attempt(16'h5916);
        TIPO_TRANS = 1'b0; MONTO = 32'd5000; MONTO_STB = 1'b1;
        #3;
        do_reset("reset_pending");

        // Two wrong then correct: warning clears on acceptance
        card_in(16'h5916);
        attempt(16'h4916); attempt(16'h5917); check_all("warn_on");
        attempt(16'h5916); check_all("warn_clear");
        amount(1'b0, 32'd8000); check_all("dep8000");
        card_out(); check_all("dep8000_out");

        // Removal mid-PIN clears attempts; removal beats a same-cycle digit strobe
        card_in(16'h5916);
        attempt(16'h4916);
        MONTO_STB = 1'b1; tick(); MONTO_STB = 1'b0;
        key(4'd6); key(4'd1);
        DIGITO = 4'd9; DIGITO_STB = 1'b1; TARJETA_RECIBIDA = 1'b0;
        tick(); DIGITO_STB = 1'b0; tick();
        m_att = 0; m_warn = 1'b0;
        check_all("mid_removal");
        card_in(16'h5916);
        attempt(16'h4916); attempt(16'h4916); check_all("after_removal");
        card_out(); check_all("after_removal_out");

        // Randomized sessions
        for (int s = 0; s < 30; s++) begin
            card_in(rand_pin());
            done = 1'b0;
            for (int a = 0; a < 3 && !done; a++) begin
                ent = ($urandom_range(0, 2) == 0) ? wrong_pin(cur_pin) : cur_pin;
                attempt(ent);
                check_all("rnd_pin");
                if (ent == cur_pin || m_lock) done = 1'b1;
            end
            if (!m_lock) begin
                tipo = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0 && m_bal < 64'h1_0000_0000) monto = m_bal[31:0];
                else monto = 32'($urandom_range(0, 50000));
                amount(tipo, monto);
                check_all("rnd_amount");
            end
            card_out();
            check_all("rnd_out");
            if (m_lock) do_reset("rnd_reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
